// File: rtl/fifo_pkg.sv
// Shared definitions for the custom_fifo read/write engines: widths, reader
// state encoding and the FIFO read latency.
package fifo_pkg;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 11;
    // read_data is valid this many cycles after read_enable
    localparam int RD_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SEND,
        ST_BACKOFF,
        ST_DROP_FETCH,
        ST_DONE
    } reader_state_t;
endpackage

// File: rtl/fifo_packet_reader_if.sv
// FIFO pop side and transmit byte stream seen by the packet reader.
interface fifo_packet_reader_if;
    import fifo_pkg::*;

    logic [DATA_W-1:0] read_data;
    logic              fifo_empty;
    logic              read_enable;
    logic              read_start;
    logic              read_error;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;
    logic              tx_abort;

    modport master (
        input  read_data, fifo_empty, tx_ready, tx_abort,
        output read_enable, read_start, read_error, tx_data, tx_valid, tx_last
    );
    modport slave (
        output read_data, fifo_empty, tx_ready, tx_abort,
        input  read_enable, read_start, read_error, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/backoff_counter.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module backoff_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/fifo_packet_reader.sv
// Drains one committed packet per start from custom_fifo to the tx byte stream,
// rewinding and retransmitting on abort until the retry budget is spent.
module fifo_packet_reader
    import fifo_pkg::*;
#(
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             busy,
    output logic             done,
    output logic             dropped,
    output logic [1:0]       retry_cnt,
    fifo_packet_reader_if.master bus
);
    localparam int BO_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    reader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [1:0]        retry_q, retry_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic [RD_LATENCY-1:0] rd_vld_q;
    logic              re, rs, rerr, bo_load, bo_exp, in_xfer;

    backoff_counter #(.W(BO_W)) u_backoff (
        .clk        (clk),
        .n_rst      (n_rst),
        .load_i     (bo_load),
        .load_val_i (BO_W'(BACKOFF_CYCLES - 1)),
        .expired_o  (bo_exp)
    );

    assign in_xfer = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_SEND);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        first_d = first_q;
        txd_d   = txd_q;
        re      = 1'b0;
        rs      = 1'b0;
        rerr    = 1'b0;
        bo_load = 1'b0;
        if (in_xfer && bus.tx_abort) begin
            // abort wins over tx_ready and suppresses any pop this cycle
            if (int'(retry_q) < MAX_RETRY) begin
                rerr    = 1'b1;
                idx_d   = '0;
                retry_d = retry_q + 2'd1;
                first_d = 1'b1;
                bo_load = 1'b1;
                state_d = ST_BACKOFF;
            end else begin
                state_d = ST_DROP_FETCH;
            end
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    if (pkt_len != '0) begin
                        len_d   = pkt_len;
                        idx_d   = '0;
                        retry_d = '0;
                        first_d = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_FETCH: if (!bus.fifo_empty) begin
                    re      = 1'b1;
                    rs      = first_q;
                    first_d = 1'b0;
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = ST_WAIT;
                end
                ST_WAIT: if (rd_vld_q[RD_LATENCY-1]) begin
                    txd_d   = bus.read_data;
                    state_d = ST_SEND;
                end
                ST_SEND: if (bus.tx_ready)
                    state_d = (idx_q == len_q) ? ST_DONE : ST_FETCH;
                ST_BACKOFF: if (bo_exp) state_d = ST_FETCH;
                ST_DROP_FETCH: begin
                    if (idx_q == len_q) begin
                        state_d = ST_IDLE;
                    end else if (!bus.fifo_empty) begin
                        re    = 1'b1;
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            first_q  <= 1'b0;
            txd_q    <= '0;
            rd_vld_q <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            first_q  <= first_d;
            txd_q    <= txd_d;
            rd_vld_q <= RD_LATENCY'({rd_vld_q, re});
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);
    assign dropped         = (state_q == ST_DROP_FETCH) && (idx_q == len_q);
    assign retry_cnt       = retry_q;
    assign bus.read_enable = re;
    assign bus.read_start  = rs;
    assign bus.read_error  = rerr;
    assign bus.tx_data     = txd_q;
    assign bus.tx_valid    = (state_q == ST_SEND);
    assign bus.tx_last     = (state_q == ST_SEND) && (idx_q == len_q);
endmodule

// File: tb/tb_fifo_packet_reader.sv
// Directed bench for fifo_packet_reader with a rewindable FIFO model and a tx monitor.
module tb_fifo_packet_reader;
    import fifo_pkg::*;

    logic             clk;
    logic             n_rst;
    logic             start;
    logic [LEN_W-1:0] pkt_len;
    logic             busy, done, dropped;
    logic [1:0]       retry_cnt;

    fifo_packet_reader_if bus();

    fifo_packet_reader #(.MAX_RETRY(3), .BACKOFF_CYCLES(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .pkt_len   (pkt_len),
        .busy      (busy),
        .done      (done),
        .dropped   (dropped),
        .retry_cnt (retry_cnt),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pop on read_enable, mark on read_start, rewind on read_error
    logic [7:0] mem [256];
    int         wr, rd, mark;
    logic [7:0] rdata;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd    <= 0;
            mark  <= 0;
            rdata <= 8'h00;
        end else if (bus.read_error) begin
            rd <= mark;
        end else if (bus.read_enable) begin
            if (bus.read_start) mark <= rd;
            rdata <= mem[rd % 256];
            rd    <= rd + 1;
        end
    end
    assign bus.read_data  = rdata;
    assign bus.fifo_empty = (rd == wr);

    // monitor, sampled mid-cycle
    int         cyc, n_re, n_rs, n_rerr, n_done, n_drop, n_viol, n_tx, err_cyc, rs_cyc;
    logic [7:0] txlog  [256];
    logic       lastlog[256];

    always @(negedge clk) begin
        if (n_rst) begin
            cyc = cyc + 1;
            if (bus.read_enable) n_re = n_re + 1;
            if (bus.read_start) begin n_rs = n_rs + 1; rs_cyc = cyc; end
            if (bus.read_error) begin n_rerr = n_rerr + 1; err_cyc = cyc; end
            if (done) n_done = n_done + 1;
            if (dropped) n_drop = n_drop + 1;
            if (bus.read_enable && bus.fifo_empty) n_viol = n_viol + 1;
            if (bus.tx_valid && bus.tx_ready && !bus.tx_abort && n_tx < 256) begin
                txlog[n_tx]   = bus.tx_data;
                lastlog[n_tx] = bus.tx_last;
                n_tx = n_tx + 1;
            end
        end
    end

    int n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr % 256] = b;
        wr = wr + 1;
    endtask

    task automatic go(input int len);
        start   = 1'b1;
        pkt_len = LEN_W'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 600) begin tick(); n++; end
        chk({tag, "_timeout"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.tx_valid && n < 200) begin tick(); n++; end
        chk({tag, "_valid_timeout"}, {31'b0, bus.tx_valid}, 32'd1);
    endtask

    int b_re, b_rs, b_rerr, b_done, b_drop, b_tx, aborts;
    logic held_ok;

    initial begin
        cyc = 0; n_re = 0; n_rs = 0; n_rerr = 0; n_done = 0; n_drop = 0; n_viol = 0;
        n_tx = 0; err_cyc = 0; rs_cyc = 0; n_chk = 0; n_err = 0; wr = 0;
        n_rst = 1'b0; start = 1'b0; pkt_len = '0;
        bus.tx_ready = 1'b0; bus.tx_abort = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_outs", {26'b0, done, dropped, bus.read_enable, bus.read_start,
                         bus.read_error, bus.tx_valid}, 0);
        chk("rst_txdata", {24'b0, bus.tx_data}, 0);
        tick(); tick();
        n_rst = 1'b1;
        tick();

        // 1: plain 5-byte packet
        for (int i = 0; i < 5; i++) push(8'(i));
        bus.tx_ready = 1'b1;
        b_re = n_re; b_rs = n_rs; b_done = n_done; b_tx = n_tx;
        go(5);
        wait_idle("t1");
        chk("t1_ntx", n_tx - b_tx, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t1_byte", {24'b0, txlog[b_tx + i]}, i);
            chk("t1_last", {31'b0, lastlog[b_tx + i]}, (i == 4) ? 1 : 0);
        end
        chk("t1_nre", n_re - b_re, 5);
        chk("t1_nrs", n_rs - b_rs, 1);
        chk("t1_done", n_done - b_done, 1);
        chk("t1_empty", {31'b0, bus.fifo_empty}, 1);

        // 2: single abort on byte 0xA2, retransmit after backoff
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        b_re = n_re; b_rs = n_rs; b_rerr = n_rerr; b_done = n_done; b_tx = n_tx;
        aborts = 1;
        go(4);
        for (int n = 0; n < 400 && busy; n++) begin
            tick();
            bus.tx_abort = 1'b0;
            if (bus.tx_valid && bus.tx_data == 8'hA2 && aborts > 0) begin
                bus.tx_abort = 1'b1;
                aborts--;
            end
        end
        bus.tx_abort = 1'b0;
        chk("t2_timeout", {31'b0, busy}, 0);
        chk("t2_rerr", n_rerr - b_rerr, 1);
        chk("t2_gap", rs_cyc - err_cyc, 17);
        chk("t2_nrs", n_rs - b_rs, 2);
        chk("t2_nre", n_re - b_re, 7);
        chk("t2_ntx", n_tx - b_tx, 6);
        for (int i = 0; i < 4; i++)
            chk("t2_resend", {24'b0, txlog[b_tx + 2 + i]}, 32'hA0 + i);
        chk("t2_retry", {30'b0, retry_cnt}, 1);
        chk("t2_done", n_done - b_done, 1);

        // 3: abort every attempt, retries exhausted, packet dropped
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        b_re = n_re; b_rerr = n_rerr; b_done = n_done; b_drop = n_drop; b_tx = n_tx;
        aborts = 4;
        go(3);
        for (int n = 0; n < 600 && busy; n++) begin
            tick();
            bus.tx_abort = 1'b0;
            if (bus.tx_valid && aborts > 0) begin
                bus.tx_abort = 1'b1;
                aborts--;
            end
        end
        bus.tx_abort = 1'b0;
        chk("t3_timeout", {31'b0, busy}, 0);
        chk("t3_rerr", n_rerr - b_rerr, 3);
        chk("t3_retry", {30'b0, retry_cnt}, 3);
        chk("t3_drop", n_drop - b_drop, 1);
        chk("t3_done", n_done - b_done, 0);
        chk("t3_ntx", n_tx - b_tx, 0);
        chk("t3_nre", n_re - b_re, 6);
        chk("t3_empty", {31'b0, bus.fifo_empty}, 1);

        // 4: FIFO underflow mid-packet stalls FETCH
        push(8'h10); push(8'h11);
        b_re = n_re; b_tx = n_tx; b_done = n_done;
        go(6);
        for (int i = 0; i < 20; i++) tick();
        chk("t4_stall_nre", n_re - b_re, 2);
        chk("t4_stall_busy", {31'b0, busy}, 1);
        for (int i = 2; i < 6; i++) push(8'h10 + 8'(i));
        wait_idle("t4");
        chk("t4_ntx", n_tx - b_tx, 6);
        for (int i = 0; i < 6; i++) chk("t4_byte", {24'b0, txlog[b_tx + i]}, 32'h10 + i);
        chk("t4_nre", n_re - b_re, 6);
        chk("t4_viol", n_viol, 0);
        chk("t4_done", n_done - b_done, 1);

        // 5: backpressure holds byte 0x33
        push(8'h33); push(8'h34);
        bus.tx_ready = 1'b0;
        b_tx = n_tx;
        go(2);
        wait_valid("t5");
        b_re = n_re;
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!bus.tx_valid || bus.tx_data !== 8'h33) held_ok = 1'b0;
            tick();
        end
        chk("t5_held", {31'b0, held_ok}, 1);
        chk("t5_hold_nre", n_re - b_re, 0);
        bus.tx_ready = 1'b1;
        wait_idle("t5");
        chk("t5_ntx", n_tx - b_tx, 2);
        chk("t5_b0", {24'b0, txlog[b_tx]}, 32'h33);
        chk("t5_b1", {24'b0, txlog[b_tx + 1]}, 32'h34);

        // 6: reset mid-SEND, then zero-length packet
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        bus.tx_ready = 1'b0;
        go(4);
        wait_valid("t6");
        n_rst = 1'b0;
        #1;
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_outs", {26'b0, done, dropped, bus.read_enable, bus.read_start,
                        bus.read_error, bus.tx_valid}, 0);
        chk("t6_txdata", {24'b0, bus.tx_data}, 0);
        chk("t6_retry", {30'b0, retry_cnt}, 0);
        wr = 0;
        tick(); tick();
        n_rst = 1'b1;
        tick();
        b_re = n_re;
        go(0);
        chk("t6_len0_done", {31'b0, done}, 1);
        tick();
        chk("t6_len0_done_off", {31'b0, done}, 0);
        chk("t6_len0_idle", {31'b0, busy}, 0);
        chk("t6_len0_nre", n_re - b_re, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_packet_reader.md
Name: fifo_packet_reader

Overview:
Consumer-side engine for custom_fifo. It drains exactly one committed packet per start command and streams the bytes to the Ethernet transmit path over a valid/ready byte interface. It marks each packet's rewind point with read_start. On a downstream abort it rolls the FIFO back with read_error and retransmits, up to MAX_RETRY times, then discards the rest of the packet.

Parameters:
DATA_W, 8, byte width of FIFO and tx data
LEN_W, 11, width of packet length field (max 2047 bytes)
MAX_RETRY, 3, retransmissions allowed after the first attempt
BACKOFF_CYCLES, 16, idle cycles between abort and retransmit

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin packet; sampled only in IDLE
pkt_len  in  LEN_W  packet byte count, captured with start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse; packet fully accepted downstream
dropped  out  1  one-cycle pulse; packet discarded after retries exhausted
retry_cnt  out  2  retries used on current/last packet
read_data  in  DATA_W  FIFO output; valid the cycle after read_enable
fifo_empty  in  1  FIFO empty flag
read_enable  out  1  pop one byte
read_start  out  1  mark rewind point; asserted with the first read_enable of each attempt
read_error  out  1  one-cycle pulse; rewind FIFO read pointer to the mark
tx_data  out  DATA_W  byte to transmitter
tx_valid  out  1  tx_data valid
tx_last  out  1  final byte of packet, qualified by tx_valid
tx_ready  in  1  transmitter accepts byte when tx_valid&&tx_ready
tx_abort  in  1  transmitter aborted frame (collision/underrun)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, tx_data 0.
- States: IDLE, FETCH, WAIT, SEND, BACKOFF, DROP_FETCH, DONE.
- IDLE:
  - start with pkt_len!=0: latch len, clear byte_idx and retry_cnt, go to FETCH with first=1.
  - start with pkt_len==0: pulse done next cycle, no FIFO access.
- FETCH:
  - If !fifo_empty: read_enable=1, read_start=first, clear first, byte_idx++, go to WAIT.
  - If fifo_empty: stall with read_enable=0.
- WAIT: capture read_data into tx_data, go to SEND.
- SEND:
  - tx_valid=1; tx_last=(byte_idx==len).
  - On tx_ready: if last, go to DONE; else go to FETCH.
  - tx_data and tx_valid stay stable until accepted.
- DONE: done=1 for one cycle, then IDLE.
- Sustained rate: one byte per 3 cycles with tx_ready held high.
- tx_abort in FETCH/WAIT/SEND:
  - If retry_cnt<MAX_RETRY: read_error=1 that cycle, tx_valid drops next cycle, byte_idx=0, retry_cnt++, first=1, go to BACKOFF. No read_enable in the abort cycle.
  - Else: no read_error; go to DROP_FETCH.
- BACKOFF: count BACKOFF_CYCLES cycles, then FETCH. tx_abort ignored.
- DROP_FETCH:
  - Pop remaining len-byte_idx bytes (read_enable when !fifo_empty), no tx output.
  - When byte_idx==len: dropped=1 for one cycle, then IDLE.
- tx_abort is ignored in IDLE, DONE and DROP_FETCH. Abort takes priority over tx_ready in the same cycle.
- start outside IDLE is ignored.
- byte_idx width is LEN_W and does not wrap within a valid packet.
- Reset mid-packet: immediate return to IDLE. FIFO state is not touched; the FIFO is reset by the same n_rst.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_W and LEN_W constants
  - state enum reader_state_t
  - the rule "read_data valid one cycle after read_enable"
- Natural sub-module: backoff_counter (load/count/expire flag), reusable by the write-side engine.

Test Plan:
1. FIFO preloaded with 0x00..0x04, start len=5, tx_ready=1 -> tx bytes 0..4, tx_last on 0x04, read_start only with the first pop, done pulse, fifo_empty=1, busy=0.
2. len=4 with 0xA0..0xA3, tx_abort during byte 2 -> read_error one cycle, 16 idle cycles, resend from 0xA0 with read_start, retry_cnt=1, done.
3. len=3, tx_abort on every attempt (4 aborts) -> three read_error pulses, retry_cnt=3, the fourth abort issues no read_error, remaining bytes popped silently, dropped pulse, FIFO empty.
4. start len=6 with only 2 bytes present, 4 more written 20 cycles later -> FETCH stalls with read_enable=0 while empty, output order 0..5 preserved, no spurious pops.
5. tx_ready low for 10 cycles on byte 0x33 -> tx_data=0x33 and tx_valid held stable, no extra read_enable.
6. n_rst asserted mid-SEND -> all outputs 0 asynchronously. start len=0 after reset -> done next cycle, no read_enable.
